// File: rtl/process_element_vec.sv
// -----------------------------------------------------------------------------
// process_element_vec
//
// Vector multiply-accumulate processing element. Each accepted input beat
// carries NUM_LANES pairs of signed fixed-point operands. The lane products
// are summed and added to a wide accumulator. On the last beat of a group the
// accumulator is rounded (half toward +inf), shifted back to operand scale and
// saturated to WIDTH_DATA bits. The unrounded accumulator is retained, so a
// following group can continue from it (keep_data_i=1 on its first beat).
//
// Pipeline (one beat per cycle, a global stall when the output is blocked):
//   products -> lane sum -> accumulator -> rounded/saturated output register
// A last beat accepted at edge N presents its result after edge N+3.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   in_valid_i   input beat valid
//   in_ready_o   input beat accepted when in_valid_i & in_ready_o at an edge
//   keep_data_i  first beat of a group only: 1 continue, 0 start from zero
//   last_i       final beat of an accumulation group
//   data_a_i     lane k operand A in bits [k*WIDTH_DATA +: WIDTH_DATA]
//   data_b_i     lane k operand B, same packing
//   out_valid_o  result valid, held until consumed
//   out_ready_i  result consumed when out_valid_o & out_ready_i at an edge
//   data_o       rounded, saturated result
//   sat_o        set with data_o when the result was clipped
// -----------------------------------------------------------------------------
module process_element_vec #(
    parameter int WIDTH_DATA = 16,
    parameter int FRAC_BITS  = 9,
    parameter int NUM_LANES  = 4,
    parameter int WIDTH_ACC  = 40
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic                            keep_data_i,
    input  logic                            last_i,
    input  logic [NUM_LANES*WIDTH_DATA-1:0] data_a_i,
    input  logic [NUM_LANES*WIDTH_DATA-1:0] data_b_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [WIDTH_DATA-1:0]           data_o,
    output logic                            sat_o
);

    localparam int WP = 2 * WIDTH_DATA;

    // Group state encoding
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;

    // Rounding constant 2^(FRAC_BITS-1), one bit wider than the accumulator
    localparam logic [WIDTH_ACC:0] RND_CONST = {{WIDTH_ACC{1'b0}}, 1'b1} << (FRAC_BITS - 1);

    // Output range limits, both in accumulator-plus-one width and data width
    localparam logic [WIDTH_DATA-1:0] DATA_MAX = {1'b0, {(WIDTH_DATA-1){1'b1}}};
    localparam logic [WIDTH_DATA-1:0] DATA_MIN = {1'b1, {(WIDTH_DATA-1){1'b0}}};
    localparam logic signed [WIDTH_ACC:0] SAT_MAX = (WIDTH_ACC+1)'($signed(DATA_MAX));
    localparam logic signed [WIDTH_ACC:0] SAT_MIN = (WIDTH_ACC+1)'($signed(DATA_MIN));

    // Handshake / control
    logic                        w_advance;
    logic                        w_accept;
    logic                        w_keep_eff;
    logic [0:0]                  r_grp_state;

    // Stage: products
    logic signed [WP-1:0]        w_prod [NUM_LANES];
    logic signed [WP-1:0]        r_prod [NUM_LANES];
    logic                        r_p_valid;
    logic                        r_p_last;
    logic                        r_p_keep;

    // Stage: lane sum
    logic [WIDTH_ACC-1:0]        w_lane_sum;
    logic [WIDTH_ACC-1:0]        r_sum;
    logic                        r_s_valid;
    logic                        r_s_last;
    logic                        r_s_keep;

    // Stage: accumulator
    logic [WIDTH_ACC-1:0]        w_acc_base;
    logic [WIDTH_ACC-1:0]        w_acc_next;
    logic [WIDTH_ACC-1:0]        r_acc;
    logic                        r_a_valid;
    logic                        r_a_last;

    // Stage: round / saturate / output
    logic signed [WIDTH_ACC:0]   w_rnd;
    logic signed [WIDTH_ACC:0]   w_shift;
    logic [WIDTH_DATA-1:0]       w_sat_data;
    logic                        w_sat_flag;
    logic                        r_out_valid;
    logic [WIDTH_DATA-1:0]       r_data;
    logic                        r_sat;

    // The whole pipeline moves together; it only stops when a held result blocks it
    assign w_advance   = out_ready_i | ~r_out_valid;
    assign in_ready_o  = w_advance;
    assign w_accept    = in_valid_i & w_advance;

    assign out_valid_o = r_out_valid;
    assign data_o      = r_data;
    assign sat_o       = r_sat;

    // Effective keep flag: only the first beat of a group may restart from zero
    always_comb begin
        w_keep_eff = 1'b1;
        case (r_grp_state)
            ST_IDLE:  w_keep_eff = keep_data_i;
            ST_ACCUM: w_keep_eff = 1'b1;
            default:  w_keep_eff = 1'b1;
        endcase
    end

    // Group state: open on a non-last beat, close on a last beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grp_state <= ST_IDLE;
        end else if (w_accept) begin
            r_grp_state <= last_i ? ST_IDLE : ST_ACCUM;
        end
    end

    // Signed lane products; size casts sign-extend the operands first
    always_comb begin
        for (int k = 0; k < NUM_LANES; k++) begin
            w_prod[k] = WP'($signed(data_a_i[k*WIDTH_DATA +: WIDTH_DATA]))
                      * WP'($signed(data_b_i[k*WIDTH_DATA +: WIDTH_DATA]));
        end
    end

    // Product stage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_valid <= 1'b0;
            r_p_last  <= 1'b0;
            r_p_keep  <= 1'b0;
            for (int k = 0; k < NUM_LANES; k++) begin
                r_prod[k] <= '0;
            end
        end else if (w_advance) begin
            r_p_valid <= in_valid_i;
            r_p_last  <= last_i;
            r_p_keep  <= w_keep_eff;
            for (int k = 0; k < NUM_LANES; k++) begin
                r_prod[k] <= w_prod[k];
            end
        end
    end

    // Sign-extended sum of all lane products
    always_comb begin
        w_lane_sum = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            w_lane_sum = w_lane_sum + WIDTH_ACC'(r_prod[k]);
        end
    end

    // Lane-sum stage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_valid <= 1'b0;
            r_s_last  <= 1'b0;
            r_s_keep  <= 1'b0;
            r_sum     <= '0;
        end else if (w_advance) begin
            r_s_valid <= r_p_valid;
            r_s_last  <= r_p_last;
            r_s_keep  <= r_p_keep;
            r_sum     <= w_lane_sum;
        end
    end

    // Accumulator base and wrap-around addition (no saturation at this width)
    always_comb begin
        if (r_s_keep) begin
            w_acc_base = r_acc;
        end else begin
            w_acc_base = '0;
        end
        w_acc_next = w_acc_base + r_sum;
    end

    // Accumulator stage; bubbles leave the accumulator untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_a_valid <= 1'b0;
            r_a_last  <= 1'b0;
        end else if (w_advance) begin
            r_a_valid <= r_s_valid;
            r_a_last  <= r_s_last;
            if (r_s_valid) begin
                r_acc <= w_acc_next;
            end
        end
    end

    // Round half toward +inf, rescale, clip to the output range
    always_comb begin
        w_rnd   = $signed({r_acc[WIDTH_ACC-1], r_acc}) + $signed(RND_CONST);
        w_shift = w_rnd >>> FRAC_BITS;
        if (w_shift > SAT_MAX) begin
            w_sat_data = DATA_MAX;
            w_sat_flag = 1'b1;
        end else if (w_shift < SAT_MIN) begin
            w_sat_data = DATA_MIN;
            w_sat_flag = 1'b1;
        end else begin
            w_sat_data = w_shift[WIDTH_DATA-1:0];
            w_sat_flag = 1'b0;
        end
    end

    // Output register: load on a completed group, clear valid once consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_data      <= '0;
            r_sat       <= 1'b0;
        end else if (w_advance) begin
            if (r_a_valid && r_a_last) begin
                r_out_valid <= 1'b1;
                r_data      <= w_sat_data;
                r_sat       <= w_sat_flag;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_process_element_vec.sv
// -----------------------------------------------------------------------------
// Bench for process_element_vec (default parameters, 1.0 = 0x0200).
// Stimulus pushes the hand-computed result of every completed group into a
// queue; an independent monitor pops and compares on each output handshake.
// -----------------------------------------------------------------------------
module tb_process_element_vec;

    localparam int W = 16;
    localparam int L = 4;

    localparam logic [W-1:0] ONE = 16'h0200;
    localparam logic [W-1:0] Z   = 16'h0000;
    localparam logic [W-1:0] PMX = 16'h7FFF;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid_i;
    logic           in_ready_o;
    logic           keep_data_i;
    logic           last_i;
    logic [L*W-1:0] data_a_i;
    logic [L*W-1:0] data_b_i;
    logic           out_valid_o;
    logic           out_ready_i;
    logic [W-1:0]   data_o;
    logic           sat_o;

    int checks   = 0;
    int failures = 0;

    // Expected results: {sat, data}
    logic [W:0] exp_q[$];

    always #5 clk = ~clk;

    process_element_vec dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .keep_data_i (keep_data_i),
        .last_i      (last_i),
        .data_a_i    (data_a_i),
        .data_b_i    (data_b_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .data_o      (data_o),
        .sat_o       (sat_o)
    );

    function automatic logic [L*W-1:0] pk(input logic [W-1:0] l0, input logic [W-1:0] l1,
                                          input logic [W-1:0] l2, input logic [W-1:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one beat; waits (bounded) for in_ready_o, returns just after the accepting edge
    task automatic send(input logic [L*W-1:0] a, input logic [L*W-1:0] b, input logic keep,
                        input logic last, input logic push, input logic [W:0] exp);
        int waited;
        waited = 0;
        @(negedge clk);
        in_valid_i  = 1'b1;
        data_a_i    = a;
        data_b_i    = b;
        keep_data_i = keep;
        last_i      = last;
        #1;
        while (in_ready_o !== 1'b1 && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (waited >= 200) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready_o=%b expected 1", in_ready_o);
        end else if (push) begin
            exp_q.push_back(exp);
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid_i  = 1'b0;
        last_i      = 1'b0;
        keep_data_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: pending=%0d expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    // Monitor: compares every output handshake against the queue head
    initial begin : monitor
        logic [W:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n === 1'b1 && out_valid_o === 1'b1 && out_ready_i === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: got data=%h sat=%b expected none", data_o, sat_o);
                end else begin
                    e = exp_q.pop_front();
                    check("result_data", 32'(data_o), 32'(e[W-1:0]));
                    check("result_sat", 32'(sat_o), 32'(e[W]));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst_n       = 1'b0;
        in_valid_i  = 1'b0;
        keep_data_i = 1'b0;
        last_i      = 1'b0;
        data_a_i    = '0;
        data_b_i    = '0;
        out_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid_o), 32'd0);
        check("reset_data", 32'(data_o), 32'd0);
        check("reset_sat", 32'(sat_o), 32'd0);
        check("reset_in_ready", 32'(in_ready_o), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Unity in all lanes, plus exact three-cycle latency
        send(pk(ONE, ONE, ONE, ONE), pk(ONE, ONE, ONE, ONE), 1'b0, 1'b1, 1'b1, {1'b0, 16'h0800});
        idle();
        @(negedge clk);
        @(negedge clk);
        #1;
        check("latency_not_early", 32'(out_valid_o), 32'd0);
        @(negedge clk);
        #1;
        check("latency_exact", 32'(out_valid_o), 32'd1);
        drain();

        // Single-lane signs, rounding of halves, mixed lanes (back-to-back groups)
        send(pk(16'hFE00, Z, Z, Z), pk(ONE, Z, Z, Z), 1'b0, 1'b1, 1'b1, {1'b0, 16'hFE00});
        send(pk(16'h0010, Z, Z, Z), pk(16'h0010, Z, Z, Z), 1'b0, 1'b1, 1'b1, {1'b0, 16'h0001});
        send(pk(16'h0010, Z, Z, Z), pk(16'hFFF0, Z, Z, Z), 1'b0, 1'b1, 1'b1, {1'b0, 16'h0000});
        send(pk(ONE, 16'h0400, 16'h0300, Z), pk(16'h0100, 16'hFF00, 16'h0300, Z),
             1'b0, 1'b1, 1'b1, {1'b0, 16'h0380});
        idle();
        drain();

        // Four-beat saturating groups, positive then negative
        for (int i = 0; i < 4; i++) begin
            send(pk(PMX, PMX, PMX, PMX), pk(PMX, PMX, PMX, PMX), 1'b0, (i == 3), (i == 3),
                 {1'b1, 16'h7FFF});
        end
        for (int i = 0; i < 4; i++) begin
            send(pk(PMX, PMX, PMX, PMX), pk(16'h8001, 16'h8001, 16'h8001, 16'h8001),
                 1'b0, (i == 3), (i == 3), {1'b1, 16'h8000});
        end
        idle();
        drain();

        // Bubbles inside a group; keep=0 on a non-first beat must be ignored
        send(pk(ONE, Z, Z, Z), pk(ONE, Z, Z, Z), 1'b0, 1'b0, 1'b0, {1'b0, 16'h0000});
        idle();
        idle();
        send(pk(ONE, Z, Z, Z), pk(ONE, Z, Z, Z), 1'b0, 1'b1, 1'b1, {1'b0, 16'h0400});
        idle();
        drain();

        // Retained accumulator across groups
        send(pk(ONE, ONE, ONE, ONE), pk(ONE, ONE, ONE, ONE), 1'b0, 1'b1, 1'b1, {1'b0, 16'h0800});
        send(pk(ONE, ONE, ONE, ONE), pk(ONE, ONE, ONE, ONE), 1'b1, 1'b1, 1'b1, {1'b0, 16'h1000});
        send(pk(ONE, ONE, ONE, ONE), pk(ONE, ONE, ONE, ONE), 1'b0, 1'b1, 1'b1, {1'b0, 16'h0800});
        idle();
        drain();

        // Output stalled across three back-to-back groups
        @(negedge clk);
        out_ready_i = 1'b0;
        send(pk(ONE, ONE, ONE, ONE), pk(ONE, ONE, ONE, ONE), 1'b0, 1'b1, 1'b1, {1'b0, 16'h0800});
        send(pk(ONE, ONE, Z, Z), pk(ONE, ONE, Z, Z), 1'b0, 1'b1, 1'b1, {1'b0, 16'h0400});
        send(pk(ONE, Z, Z, Z), pk(ONE, Z, Z, Z), 1'b0, 1'b1, 1'b1, {1'b0, 16'h0200});
        idle();
        repeat (4) @(negedge clk);
        #1;
        check("stall_in_ready_low", 32'(in_ready_o), 32'd0);
        check("stall_out_valid", 32'(out_valid_o), 32'd1);
        check("stall_data_head", 32'(data_o), 32'h0800);
        repeat (3) @(negedge clk);
        #1;
        check("stall_data_stable", 32'(data_o), 32'h0800);
        check("stall_valid_stable", 32'(out_valid_o), 32'd1);
        @(negedge clk);
        out_ready_i = 1'b1;
        drain();
        @(negedge clk);
        #1;
        check("stall_no_duplicate", 32'(out_valid_o), 32'd0);

        // Reset with a held saturated result and an open group in flight
        @(negedge clk);
        out_ready_i = 1'b0;
        send(pk(PMX, PMX, PMX, PMX), pk(PMX, PMX, PMX, PMX), 1'b0, 1'b1, 1'b0, {1'b1, 16'h7FFF});
        send(pk(ONE, ONE, ONE, ONE), pk(ONE, ONE, ONE, ONE), 1'b0, 1'b0, 1'b0, {1'b0, 16'h0000});
        idle();
        repeat (4) @(negedge clk);
        #1;
        check("prereset_held_valid", 32'(out_valid_o), 32'd1);
        check("prereset_held_sat", 32'(sat_o), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", 32'(out_valid_o), 32'd0);
        check("midreset_data", 32'(data_o), 32'd0);
        check("midreset_sat", 32'(sat_o), 32'd0);
        check("midreset_in_ready", 32'(in_ready_o), 32'd1);
        @(negedge clk);
        rst_n       = 1'b1;
        out_ready_i = 1'b1;
        send(pk(ONE, Z, Z, Z), pk(ONE, Z, Z, Z), 1'b1, 1'b1, 1'b1, {1'b0, 16'h0200});
        idle();
        drain();
        repeat (3) @(negedge clk);
        #1;
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_out_idle", 32'(out_valid_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
